// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, oversampling
// constants and a 3-sample majority vote helper.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1, ticks at terminal count and
// restarts from 0 when the receiver detects a start edge.
module uart_baud_tick #(
    parameter int unsigned DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int W = $clog2(DIV);
    localparam logic [W-1:0] TERM = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || cnt == TERM) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == TERM);

endmodule

// File: rtl/uart_rx_ovs.sv
// 16x oversampling UART receiver, 8N1 by default; defining UART_RX_PARITY_EN
// adds an even-parity bit (8E1) and drives parity_err.
module uart_rx_ovs
    import uart_pkg::*;
#(
    parameter int unsigned OVS_DIV = 27
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err,
    output logic                 busy
);

    logic rx_s1, rx_s2, rx_prev;
    logic start_edge;
    logic tick, restart;

    uart_state_t          state;
    logic [3:0]           sample_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 s7, s8;
    logic                 maj, mid_done, bit_end;

    logic                 pend_deliver, pend_fe;
    logic [DATA_BITS-1:0] pend_byte;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bad, pend_pe;
`endif

    // Synchronizer flops idle high so reset release cannot fake a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign start_edge = rx_prev & ~rx_s2;
    assign restart    = (state == IDLE) && start_edge;

    uart_baud_tick #(.DIV(OVS_DIV)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    assign maj      = majority3(s7, s8, rx_s2);
    assign mid_done = tick && (sample_cnt == 4'(MID_SAMPLE + 1));
    assign bit_end  = tick && (sample_cnt == 4'(OVERSAMPLE - 1));

    // Decisions are taken on sample 9 once samples 7 and 8 are held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sample_cnt   <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            s7           <= 1'b0;
            s8           <= 1'b0;
            busy         <= 1'b0;
            pend_deliver <= 1'b0;
            pend_fe      <= 1'b0;
            pend_byte    <= '0;
`ifdef UART_RX_PARITY_EN
            parity_bad   <= 1'b0;
            pend_pe      <= 1'b0;
`endif
        end else begin
            pend_deliver <= 1'b0;
            pend_fe      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pend_pe      <= 1'b0;
`endif
            if (tick) begin
                sample_cnt <= sample_cnt + 1'b1;
            end
            if (tick && sample_cnt == 4'(MID_SAMPLE - 1)) begin
                s7 <= rx_s2;
            end
            if (tick && sample_cnt == 4'(MID_SAMPLE)) begin
                s8 <= rx_s2;
            end

            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state      <= START;
                        sample_cnt <= '0;
                        bit_cnt    <= '0;
                        busy       <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_bad <= 1'b0;
`endif
                    end
                end
                START: begin
                    if (tick && sample_cnt == 4'(MID_SAMPLE) && rx_s2) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (bit_end) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (mid_done) begin
                        shift <= {maj, shift[DATA_BITS-1:1]};
                    end
                    if (bit_end) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (mid_done) begin
                        parity_bad <= maj ^ (^shift);
                    end
                    if (bit_end) begin
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    // Leave at mid-stop so the next start edge is never missed.
                    if (mid_done) begin
                        pend_fe   <= ~maj;
                        pend_byte <= shift;
`ifdef UART_RX_PARITY_EN
                        pend_deliver <= maj & ~parity_bad;
                        pend_pe      <= parity_bad;
`else
                        pend_deliver <= maj;
`endif
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Output buffer: rx_valid/rx_ready handshake, new byte dropped when blocked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= pend_fe;
            overrun   <= 1'b0;
            if (pend_deliver) begin
                if (rx_valid && !rx_ready) begin
                    overrun <= 1'b1;
                end else begin
                    rx_data  <= pend_byte;
                    rx_valid <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= pend_pe;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs with a frame-level model and event scoreboard.
`timescale 1ns/1ps
module tb_uart_rx_ovs;

    localparam int OVS_DIV = 4;
    localparam int BIT     = 16 * OVS_DIV;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 10;
`else
    localparam int NBITS = 9;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, parity_err, busy;

    uart_rx_ovs #(.OVS_DIV(OVS_DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err),
        .busy       (busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // scoreboard: {frame_err, parity_err, byte} per frame, with arrival window
    logic [9:0] exp_q[$];
    int         lo_q[$];
    int         hi_q[$];

    bit         mv = 1'b0;
    logic [7:0] md = 8'h00;
    bit         pv = 1'b0;
    logic [7:0] pd = 8'h00;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         pe_cnt = 0;
    int         valid_cnt = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

    task automatic push_exp(input logic fe, input logic pe, input logic [7:0] d);
        exp_q.push_back({fe, pe, d});
        lo_q.push_back(cyc + NBITS * BIT);
        hi_q.push_back(cyc + (NBITS + 1) * BIT);
    endtask

    // driver tasks
    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input bit push);
        logic pe;
`ifdef UART_RX_PARITY_EN
        pe = (par != even_par(d));
`else
        pe = 1'b0;
`endif
        if (push) push_exp(~stop, pe, d);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`else
        if (par === 1'bx) check(0, "par_arg", 0, 0);
`endif
        drive_bit(stop);
        rx = 1'b1;
    endtask

    // compare process: every cycle, outputs against the frame-level model
    initial begin
        logic [9:0] e;
        int lo, hi;
        bit ev, good, eov;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                check(rx_valid == 0 && frame_err == 0 && overrun == 0 && parity_err == 0 &&
                      busy == 0 && rx_data == 8'h00, "reset_outputs",
                      {19'd0, rx_valid, frame_err, overrun, parity_err, busy, rx_data}, 0);
                mv = 0; md = 8'h00; pv = 0; pd = 8'h00;
            end else begin
                if (frame_err) fe_cnt++;
                if (overrun) ov_cnt++;
                if (parity_err) pe_cnt++;
                if (rx_valid) valid_cnt++;
                ev = frame_err | parity_err | overrun | (rx_valid & ~pv) |
                     (rx_valid & pv & (rx_data != pd));
                if (ev) begin
                    if (exp_q.size() == 0) begin
                        check(0, "unexpected_event",
                              {20'd0, frame_err, parity_err, overrun, rx_valid, rx_data}, 0);
                    end else begin
                        e  = exp_q.pop_front();
                        lo = lo_q.pop_front();
                        hi = hi_q.pop_front();
                        check(cyc >= lo && cyc <= hi, "event_time", cyc, lo);
                        good = !e[9] && !e[8];
                        eov  = good && mv && !rx_ready;
                        check(frame_err == e[9], "frame_err", frame_err, e[9]);
                        check(parity_err == e[8], "parity_err", parity_err, e[8]);
                        check(overrun == eov, "overrun", overrun, eov);
                        if (good && !eov) begin
                            mv = 1; md = e[7:0];
                        end else if (mv && rx_ready) begin
                            mv = 0;
                        end
                    end
                end else if (mv && rx_ready) begin
                    mv = 0;
                end
                check(rx_valid == mv, "rx_valid", rx_valid, mv);
                check(rx_data == md, "rx_data", rx_data, md);
                if (exp_q.size() > 0 && cyc > hi_q[0]) begin
                    check(0, "event_timeout", cyc, hi_q[0]);
                    void'(exp_q.pop_front());
                    void'(lo_q.pop_front());
                    void'(hi_q.pop_front());
                end
                pv = rx_valid;
                pd = rx_data;
            end
        end
    end

    // directed stimulus
    initial begin
        int fe_base, ov_base;
        rst_n = 1'b0;
        rx = 1'b1;
        rx_ready = 1'b0;
        repeat (5) @(negedge clk);
        check(busy == 0, "reset_busy", busy, 0);
        check(rx_data == 8'h00, "reset_data", rx_data, 0);
        rst_n = 1'b1;
        idle(2 * BIT);

        // clean frame, consumer ready
        rx_ready = 1'b1;
        valid_cnt = 0;
        send_frame(8'hA5, even_par(8'hA5), 1'b1, 1'b1);
        idle(2 * BIT);
        check(rx_data == 8'hA5, "a5_data", rx_data, 8'hA5);
        check(valid_cnt == 1, "a5_valid_cycles", valid_cnt, 1);
        check(fe_cnt + ov_cnt + pe_cnt == 0, "a5_no_errors", fe_cnt + ov_cnt + pe_cnt, 0);

        // false start: 20 clocks low
        rx = 1'b0;
        repeat (10) @(negedge clk);
        check(busy == 1, "glitch_busy_high", busy, 1);
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check(busy == 0, "glitch_busy_low", busy, 0);
        check(rx_valid == 0, "glitch_no_valid", rx_valid, 0);
        idle(2 * BIT);

        // bad stop bit
        send_frame(8'h3C, even_par(8'h3C), 1'b0, 1'b1);
        idle(2 * BIT);
        check(fe_cnt == 1, "stop0_frame_err_count", fe_cnt, 1);
        check(rx_valid == 0, "stop0_no_valid", rx_valid, 0);

        // break: line low for three frame times, one frame_err only
        push_exp(1'b1, 1'b0, 8'h00);
        rx = 1'b0;
        repeat (30 * BIT) @(negedge clk);
        idle(2 * BIT);
        check(fe_cnt == 2, "break_frame_err_count", fe_cnt, 2);

        // overrun: consumer stalled
        rx_ready = 1'b0;
        ov_base = ov_cnt;
        send_frame(8'h11, even_par(8'h11), 1'b1, 1'b1);
        idle(BIT);
        send_frame(8'h22, even_par(8'h22), 1'b1, 1'b1);
        idle(BIT);
        check(rx_data == 8'h11, "overrun_data_held", rx_data, 8'h11);
        check(rx_valid == 1, "overrun_valid_held", rx_valid, 1);
        check(ov_cnt - ov_base == 1, "overrun_count", ov_cnt - ov_base, 1);
        rx_ready = 1'b1;
        @(negedge clk);
        check(rx_valid == 0, "drain_clears_valid", rx_valid, 0);
        idle(BIT);

        // reset in data bit 3 of 0x7E, then a clean 0x5A
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'(8'h7E >> i));
        rx = 1'b1;
        repeat (BIT / 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check(busy == 0, "midreset_busy", busy, 0);
        check(rx_data == 8'h00, "midreset_data", rx_data, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        fe_base = fe_cnt;
        idle(2 * BIT);
        check(fe_cnt == fe_base, "no_pulse_after_reset", fe_cnt, fe_base);
        valid_cnt = 0;
        send_frame(8'h5A, even_par(8'h5A), 1'b1, 1'b1);
        idle(2 * BIT);
        check(rx_data == 8'h5A, "post_reset_data", rx_data, 8'h5A);
        check(valid_cnt == 1, "post_reset_valid", valid_cnt, 1);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h01, 1'b0, 1'b1, 1'b1);
        idle(2 * BIT);
        check(pe_cnt == 1, "parity_bad_pulse", pe_cnt, 1);
        check(rx_data == 8'h5A, "parity_bad_dropped", rx_data, 8'h5A);
        send_frame(8'h03, 1'b0, 1'b1, 1'b1);
        idle(2 * BIT);
        check(rx_data == 8'h03, "parity_ok_data", rx_data, 8'h03);
        send_frame(8'h01, 1'b0, 1'b0, 1'b1);
        idle(2 * BIT);
        check(pe_cnt == 2 && fe_cnt == fe_base + 1, "parity_and_frame", pe_cnt, 2);
`endif

        check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_ovs.md
UART_RX_OVS -- requirements
Module: uart_rx_ovs

Interface
REQ-001 Parameter OVS_DIV, default 27, clocks per 1/16-bit oversample tick (27 = 115200 baud at 50 MHz); legal range 2..65535.
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 rx  input  1  asynchronous serial line, idle high, 8N1 (8E1 with parity option).
REQ-005 rx_ready  input  1  downstream (latch stage) accepts byte when high with rx_valid.
REQ-006 rx_data  output  8  received byte, stable while rx_valid high.
REQ-007 rx_valid  output  1  byte available; held until accepted.
REQ-008 frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-009 overrun  output  1  one-clk pulse: byte completed while buffer full and not being drained.
REQ-010 parity_err  output  1  one-clk pulse: parity mismatch (constant 0 without option).
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 rx passes a 2-flop synchronizer; all decisions use the synchronized value.
REQ-013 Tick generator counts 0..OVS_DIV-1, pulses tick at terminal count, restarts at 0 on start-edge detection in IDLE.
REQ-014 States: IDLE, START, DATA, PARITY (option only), STOP.
REQ-015 IDLE -> START on synchronized falling edge of rx; tick counter and sample counter cleared.
REQ-016 START: at oversample 8 line still low -> DATA; line high -> IDLE (false start, no outputs).
REQ-017 Each bit spans 16 ticks; bit value = majority of samples 7, 8, 9; DATA shifts 8 bits LSB first.
REQ-018 After bit 7 -> PARITY if option compiled in, else STOP.
REQ-019 STOP: at majority point, stop=1 -> byte delivered; stop=0 -> frame_err pulse, byte discarded; both -> IDLE immediately (mid-stop resync).
REQ-020 Delivery: rx_data loaded and rx_valid set on the clock after the stop decision (latency 1 clk).
REQ-021 rx_valid & rx_ready on a clock -> rx_valid clears next clock unless a new byte is delivered that same clock, in which case rx_data updates and rx_valid stays high.
REQ-022 Delivery while rx_valid high and rx_ready low -> overrun pulse, new byte dropped, rx_data/rx_valid unchanged.
REQ-023 Parity error and frame error in one frame -> both pulses same clock, byte discarded.
REQ-024 Line held low (break) -> one frame_err, then remain IDLE until rx returns high before next start detect.

Reset
REQ-025 rst_n low asynchronously forces IDLE, counters 0, shift register 0, synchronizer flops 1, rx_data 0x00, rx_valid/frame_err/overrun/parity_err/busy 0.
REQ-026 Reset mid-frame abandons the partial byte; no pulse emitted on reset release.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: PARITY state present, even parity over 8 data bits checked at majority point; mismatch -> parity_err pulse, byte discarded, continue to STOP.
REQ-028 Macro undefined: no PARITY state, parity_err tied 0, frame is 10 bits.

Structure
REQ-029 Shared package uart_pkg holds state encoding constants (IDLE..STOP), OVERSAMPLE=16, MID_SAMPLE=8, data width 8; reused by uart_tx.
REQ-030 One sub-module uart_baud_tick (tick generator with sync restart) instantiated inside; all else in uart_rx_ovs.

Verification (OVS_DIV=4, 64 clk per bit)
REQ-031 Frame 0xA5, rx_ready=1 -> rx_valid one clk, rx_data=0xA5, all error pulses 0.
REQ-032 rx low 20 clks then high (glitch) -> no rx_valid, busy returns 0 by clk 40.
REQ-033 Frame 0x3C with stop bit 0 -> frame_err single pulse, rx_valid stays 0.
REQ-034 Frames 0x11 then 0x22, rx_ready=0 -> rx_data=0x11 held, overrun pulse at 0x22 delivery; raise rx_ready -> rx_valid clears next clk.
REQ-035 rst_n low at data bit 3 of 0x7E, then frame 0x5A -> all outputs 0 during reset, then rx_data=0x5A valid.
REQ-036 UART_RX_PARITY_EN: 0x01 with parity bit 0 -> parity_err pulse, no rx_valid; 0x03 with parity 0 -> delivered.
